// File: rtl/fu_regfile.sv
// fu_regfile -- operand register file and N/Z status register around the FU.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   sa_in, sb_in          source A/B register addresses
//   mb_in, const_in       B select (1 = const_in) and immediate constant
//   a_out, b_out          combinational operands to the function unit
//   dr_in, rw_in          destination address and write enable
//   md_in, f_in, data_in  writeback select (1 = data_in) and sources
//   nz_in, sl_in, nz_out  FU flags {N,Z}, status load enable, status register
//
// Build option: define FU_REGFILE_BYPASS_EN to forward the writeback value
// to a read port that addresses the register being written in that cycle.

// One storage word. Each register owns exactly one of these, so every
// storage bit has a single driver.
module fu_regfile_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module fu_regfile #(
  parameter int NREG  = 8,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    sa_in,
  input  logic [AW-1:0]    sb_in,
  input  logic             mb_in,
  input  logic [WIDTH-1:0] const_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [AW-1:0]    dr_in,
  input  logic             rw_in,
  input  logic             md_in,
  input  logic [WIDTH-1:0] f_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       nz_in,
  input  logic             sl_in,
  output logic [1:0]       nz_out
);
  // The address space is padded to a power of two; slots at or beyond NREG
  // read as zero and have no write decode, so out-of-range writes vanish.
  localparam int NSLOT = 1 << AW;

  logic [NSLOT-1:0][WIDTH-1:0] rf;
  logic [WIDTH-1:0]            wb;
  logic [1:0]                  nz_q, nz_d;

  assign wb = md_in ? data_in : f_in;

  for (genvar r = 0; r < NSLOT; r++) begin : g_slot
    if (r < NREG) begin : g_reg
      fu_regfile_cell #(.WIDTH(WIDTH)) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (rw_in && (dr_in == AW'(r))),
        .d_i   (wb),
        .q_o   (rf[r])
      );
    end else begin : g_pad
      assign rf[r] = '0;
    end
  end

`ifdef FU_REGFILE_BYPASS_EN
  // Forward only real writes to in-range registers; while reset is held the
  // storage is being cleared, so reads stay at zero.
  logic wr_hit;
  assign wr_hit = rw_in && rst_n && ({1'b0, dr_in} < (AW+1)'(NREG));
  assign a_out  = (wr_hit && (sa_in == dr_in)) ? wb : rf[sa_in];
  assign b_out  = mb_in ? const_in
                : (wr_hit && (sb_in == dr_in)) ? wb : rf[sb_in];
`else
  assign a_out  = rf[sa_in];
  assign b_out  = mb_in ? const_in : rf[sb_in];
`endif

  // Status flags load independently of any register write.
  assign nz_d = sl_in ? nz_in : nz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nz_q <= 2'b00;
    else        nz_q <= nz_d;
  end

  assign nz_out = nz_q;
endmodule

// File: tb/tb_fu_regfile.sv
module tb_fu_regfile;
`ifdef FU_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst_n;
  logic [2:0]  sa, sb, dr;
  logic        mb, rw, md, sl;
  logic [15:0] cst, f, data;
  logic [1:0]  nz;
  logic [15:0] a8, b8, a6, b6;
  logic [1:0]  nzo8, nzo6;

  int ncmp = 0;
  int nerr = 0;

  fu_regfile #(.NREG(8), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .sa_in(sa), .sb_in(sb), .mb_in(mb),
    .const_in(cst), .a_out(a8), .b_out(b8), .dr_in(dr), .rw_in(rw),
    .md_in(md), .f_in(f), .data_in(data), .nz_in(nz), .sl_in(sl),
    .nz_out(nzo8));

  // Non-power-of-two instance to exercise out-of-range addresses.
  fu_regfile #(.NREG(6), .WIDTH(16)) dut6 (
    .clk(clk), .rst_n(rst_n), .sa_in(sa), .sb_in(sb), .mb_in(mb),
    .const_in(cst), .a_out(a6), .b_out(b6), .dr_in(dr), .rw_in(rw),
    .md_in(md), .f_in(f), .data_in(data), .nz_in(nz), .sl_in(sl),
    .nz_out(nzo6));

  always #5 clk = ~clk;

  // Reference model: plain arrays holding what each register should contain.
  logic [15:0] m8[8];
  logic [15:0] m6[6];
  logic [1:0]  mnz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m8[i] <= '0;
      for (int i = 0; i < 6; i++) m6[i] <= '0;
      mnz <= 2'b00;
    end else begin
      if (rw) m8[dr] <= md ? data : f;
      if (rw && dr < 6) m6[dr] <= md ? data : f;
      if (sl) mnz <= nz;
    end
  end

  function automatic logic [15:0] exp_rd(input int n, input logic [2:0] s, input logic isb);
    logic [15:0] wbv;
    wbv = md ? data : f;
    if (isb && mb) return cst;
    if (BYP && rst_n && rw && s == dr && int'(dr) < n) return wbv;
    if (int'(s) >= n) return 16'h0000;
    return (n == 8) ? m8[s] : m6[s];
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rw;
    logic [2:0]  dr;
    logic        md;
    logic [15:0] f, data;
    logic [2:0]  sa, sb;
    logic        mb;
    logic [15:0] cst;
    logic        sl;
    logic [1:0]  nz;
    logic [15:0] ea, eb;
    logic [1:0]  enz;
  } vec_t;

  function automatic vec_t mk(input logic rw_, input logic [2:0] dr_, input logic md_,
      input logic [15:0] f_, input logic [15:0] d_, input logic [2:0] sa_,
      input logic [2:0] sb_, input logic mb_, input logic [15:0] c_, input logic sl_,
      input logic [1:0] nz_, input logic [15:0] ea_, input logic [15:0] eb_,
      input logic [1:0] enz_);
    vec_t v;
    v.rw = rw_; v.dr = dr_; v.md = md_; v.f = f_; v.data = d_; v.sa = sa_;
    v.sb = sb_; v.mb = mb_; v.cst = c_; v.sl = sl_; v.nz = nz_;
    v.ea = ea_; v.eb = eb_; v.enz = enz_;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    // Expected outputs are the combinational values seen before the edge.
    tbl[0]  = mk(0,0,0,16'h0000,16'h0000, 3,3,0,16'h0000, 0,2'b00, 16'h0000,16'h0000,2'b00);
    tbl[1]  = mk(1,5,0,16'hBEEF,16'h0000, 0,0,0,16'h0000, 0,2'b00, 16'h0000,16'h0000,2'b00);
    tbl[2]  = mk(0,0,0,16'h0000,16'h0000, 5,5,0,16'h0000, 0,2'b00, 16'hBEEF,16'hBEEF,2'b00);
    tbl[3]  = mk(1,2,1,16'h1111,16'h00A5, 5,5,0,16'h0000, 0,2'b00, 16'hBEEF,16'hBEEF,2'b00);
    tbl[4]  = mk(1,2,0,16'h7FFF,16'h2222, 5,7,0,16'h0000, 0,2'b00, 16'hBEEF,16'h0000,2'b00);
    tbl[5]  = mk(0,0,0,16'h0000,16'h0000, 2,2,1,16'h0003, 0,2'b00, 16'h7FFF,16'h0003,2'b00);
    tbl[6]  = mk(0,0,0,16'h0000,16'h0000, 2,2,0,16'h0000, 0,2'b00, 16'h7FFF,16'h7FFF,2'b00);
    tbl[7]  = mk(0,0,0,16'h0000,16'h0000, 5,2,0,16'h0000, 1,2'b10, 16'hBEEF,16'h7FFF,2'b00);
    tbl[8]  = mk(0,0,0,16'h0000,16'h0000, 5,2,0,16'h0000, 0,2'b01, 16'hBEEF,16'h7FFF,2'b10);
    tbl[9]  = mk(0,0,0,16'h0000,16'h0000, 5,2,0,16'h0000, 0,2'b01, 16'hBEEF,16'h7FFF,2'b10);
    tbl[10] = mk(0,0,0,16'h0000,16'h0000, 5,2,0,16'h0000, 0,2'b01, 16'hBEEF,16'h7FFF,2'b10);
    tbl[11] = mk(1,1,0,16'h0042,16'h0000, 5,2,0,16'h0000, 1,2'b01, 16'hBEEF,16'h7FFF,2'b10);
    tbl[12] = mk(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000, 0,2'b00, 16'h0042,16'h0000,2'b01);
    for (int i = 13; i < 17; i++)
      tbl[i] = mk(0,6,0,16'hFFFF,16'h0000, 6,6,0,16'h0000, 0,2'b00, 16'h0000,16'h0000,2'b01);
    tbl[17] = mk(0,0,0,16'h0000,16'h0000, 6,6,0,16'h0000, 0,2'b00, 16'h0000,16'h0000,2'b01);

    clk = 0; rst_n = 0;
    sa = 0; sb = 0; dr = 0; mb = 0; rw = 0; md = 0; sl = 0;
    cst = 0; f = 0; data = 0; nz = 0;
    #2;
    chk("reset_a", a8, 16'h0000);
    chk("reset_nz", {14'b0, nzo8}, 16'h0000);
    #10 rst_n = 1;
    step();

    // Directed table.
    for (int i = 0; i < 18; i++) begin
      rw = tbl[i].rw; dr = tbl[i].dr; md = tbl[i].md; f = tbl[i].f;
      data = tbl[i].data; sa = tbl[i].sa; sb = tbl[i].sb; mb = tbl[i].mb;
      cst = tbl[i].cst; sl = tbl[i].sl; nz = tbl[i].nz;
      #1;
      chk($sformatf("tbl%0d_a", i), a8, tbl[i].ea);
      chk($sformatf("tbl%0d_b", i), b8, tbl[i].eb);
      chk($sformatf("tbl%0d_nz", i), {14'b0, nzo8}, {14'b0, tbl[i].enz});
      step();
    end

    // Same-address read/write hazard.
    rw = 1; dr = 4; md = 0; f = 16'h0001; sa = 0; sb = 0; mb = 0; sl = 0;
    step();
    f = 16'h8000; sa = 4; sb = 4;
    #1;
    chk("haz_same_a", a8, BYP ? 16'h8000 : 16'h0001);
    chk("haz_same_b", b8, BYP ? 16'h8000 : 16'h0001);
    step();
    rw = 0;
    #1;
    chk("haz_next_a", a8, 16'h8000);

    // Out-of-range addresses on the 6-entry instance.
    rw = 1; dr = 7; f = 16'hABCD; sa = 0;
    step();
    dr = 6; f = 16'h1357;
    step();
    rw = 0; sa = 7; sb = 6;
    #1;
    chk("oor_a", a6, 16'h0000);
    chk("oor_b", b6, 16'h0000);
    chk("full_r7", a8, 16'hABCD);
    chk("full_r6", b8, 16'h1357);
    step();

    // Randomized against the model.
    for (int i = 0; i < 400; i++) begin
      rw = 1'($urandom); md = 1'($urandom); mb = 1'($urandom_range(0, 3) == 0);
      sl = 1'($urandom); nz = 2'($urandom);
      dr = 3'($urandom_range(0, 7)); sa = 3'($urandom_range(0, 7));
      sb = ($urandom_range(0, 3) == 0) ? dr : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) sa = dr;
      f = 16'($urandom); data = 16'($urandom); cst = 16'($urandom);
      #1;
      chk($sformatf("rnd%0d_a8", i), a8, exp_rd(8, sa, 1'b0));
      chk($sformatf("rnd%0d_b8", i), b8, exp_rd(8, sb, 1'b1));
      chk($sformatf("rnd%0d_a6", i), a6, exp_rd(6, sa, 1'b0));
      chk($sformatf("rnd%0d_b6", i), b6, exp_rd(6, sb, 1'b1));
      chk($sformatf("rnd%0d_nz8", i), {14'b0, nzo8}, {14'b0, mnz});
      chk($sformatf("rnd%0d_nz6", i), {14'b0, nzo6}, {14'b0, mnz});
      step();
    end

    // Asynchronous reset mid-cycle, write lost under reset, first write after.
    rw = 1; dr = 3; md = 0; f = 16'h1234; sl = 1; nz = 2'b11; mb = 0;
    step();
    rw = 0; sl = 0; sa = 3; sb = 3;
    #1;
    chk("pre_rst_a", a8, 16'h1234);
    chk("pre_rst_nz", {14'b0, nzo8}, 16'h0003);
    #1 rst_n = 0;
    #1;
    chk("rst_async_a", a8, 16'h0000);
    chk("rst_async_nz", {14'b0, nzo8}, 16'h0000);
    rw = 1; dr = 3; f = 16'h5555; sa = 3;
    step();
    chk("rst_wr_lost", a8, 16'h0000);
    #2 rst_n = 1;
    #1;
    chk("post_rst_pre_edge", a8, BYP ? 16'h5555 : 16'h0000);
    step();
    rw = 0;
    #1;
    chk("first_write", a8, 16'h5555);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
